// File: rtl/vcve2_pkg.sv
// ---------------------------------------------------------------------------
// vcve2_pkg
// Shared types for the vector register file sequencer and its lane-wise ALU.
//   vrf_state_t   : sequencer FSM states
//   vop_a_sel_e   : operand A source select
//   valu_op_e     : VALU operation
//   vsew_e        : element width (3..7 reserved)
//   rd_slot_e     : operand slot a VRF read lands in
//   vinstr_t      : instruction fields latched at accept
//   vsew_valid()  : legal element width check
//   sew_splat32() : truncate a scalar to SEW and replicate it across 32 bits
// ---------------------------------------------------------------------------
package vcve2_pkg;

    localparam int VRF_ADDR_W = 5;

    typedef enum logic [2:0] {
        VRF_IDLE  = 3'd0,
        VRF_READ1 = 3'd1,
        VRF_READ2 = 3'd2,
        VRF_READ3 = 3'd3,
        VRF_V_OP  = 3'd4,
        VRF_WRITE = 3'd5
    } vrf_state_t;

    typedef enum logic [1:0] {
        VOP_A_VREG_A = 2'd0,
        VOP_A_REG_A  = 2'd1,
        VOP_A_IMM    = 2'd2
    } vop_a_sel_e;

    typedef enum logic {
        VALU_MOVE = 1'b0,
        VALU_ADD  = 1'b1
    } valu_op_e;

    typedef enum logic [2:0] {
        VSEW_8  = 3'd0,
        VSEW_16 = 3'd1,
        VSEW_32 = 3'd2
    } vsew_e;

    typedef enum logic [1:0] {
        SLOT_NONE = 2'd0,
        SLOT_B    = 2'd1,
        SLOT_A    = 2'd2,
        SLOT_VD   = 2'd3
    } rd_slot_e;

    typedef struct packed {
        logic [1:0]            num_reads;
        logic [VRF_ADDR_W-1:0] vs1;
        logic [VRF_ADDR_W-1:0] vd;
        vop_a_sel_e            a_sel;
        valu_op_e              op;
        vsew_e                 sew;
    } vinstr_t;

    function automatic logic vsew_valid(input vsew_e sew);
        return (sew == VSEW_8) || (sew == VSEW_16) || (sew == VSEW_32);
    endfunction

    function automatic logic [31:0] sew_splat32(input logic [31:0] v, input vsew_e sew);
        logic [31:0] r;
        r = v;
        case (sew)
            VSEW_8:  r = {4{v[7:0]}};
            VSEW_16: r = {2{v[15:0]}};
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vcve2_valu.sv
// ---------------------------------------------------------------------------
// vcve2_valu
// Combinational lane-wise vector ALU with tail merge.
//   op               in  VALU_MOVE (elem = A) / VALU_ADD (elem = A+B mod 2^SEW)
//   vsew             in  element width
//   a, b             in  VLEN-bit operands
//   vl               in  active element count
//   old_vd           in  previous destination contents
//   tail_undisturbed in  1: tail keeps old_vd, 0: tail is all-ones
//   result           out VLEN-bit merged result
// ---------------------------------------------------------------------------
module vcve2_valu
    import vcve2_pkg::*;
#(
    parameter int VLEN = 128
) (
    input  valu_op_e              op,
    input  vsew_e                 vsew,
    input  logic [VLEN-1:0]       a,
    input  logic [VLEN-1:0]       b,
    input  logic [$clog2(VLEN):0] vl,
    input  logic [VLEN-1:0]       old_vd,
    input  logic                  tail_undisturbed,
    output logic [VLEN-1:0]       result
);

    localparam int NBYTES = VLEN / 8;

    int         sh;
    logic       carry;
    logic [8:0] sum9;

    // One byte slice at a time; the carry chain is cut at every element
    // boundary so no carry crosses a lane. Element index = byte >> log2(SEW/8).
    // The highest element index is VLEN/SEW-1, so any vl above that behaves
    // as a clamp to VLEN/SEW.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        sum9   = '0;
        sh     = vsew_valid(vsew) ? int'(vsew) : 0;
        for (int j = 0; j < NBYTES; j++) begin
            if ((j & ((1 << sh) - 1)) == 0) carry = 1'b0;
            sum9  = {1'b0, a[j*8 +: 8]} + {1'b0, b[j*8 +: 8]} + {8'd0, carry};
            carry = sum9[8];
            if ((j >> sh) < int'(vl))
                result[j*8 +: 8] = (op == VALU_ADD) ? sum9[7:0] : a[j*8 +: 8];
            else
                result[j*8 +: 8] = tail_undisturbed ? old_vd[j*8 +: 8] : 8'hFF;
        end
    end

endmodule

// File: rtl/vcve2_vrf_seq.sv
// ---------------------------------------------------------------------------
// vcve2_vrf_seq
// Sequencer between ID and a single-port VRF. Runs one vector instruction at
// a time: up to three source reads (vs2, vs1, old vd), one lane-wise ALU op,
// one write back to vd.
//   clk_i / rst_ni           clock, async active-low reset
//   vinstr_valid_i/ready_o   ID handshake (ready only while idle)
//   flush_i                  abort an in-flight instruction (not in write)
//   num_reads_i, vs*_addr_i, vd_addr_i, vop_a_sel_i, valu_op_i, vsew_i,
//   vl_i, rs1_data_i, imm_i  decoded instruction fields
//   vrf_req_o/we_o/addr_o/wdata_o, vrf_rdata_i   VRF port (read data 1 cycle later)
//   vinstr_done_o/err_o      retire pulse; err = reserved SEW, nothing written
//   vinstr_cnt_o             (VCVE2_VRF_SEQ_PERF_EN only) count of clean retires,
//                            saturating
// Optional feature macro: VCVE2_VRF_SEQ_PERF_EN
// ---------------------------------------------------------------------------
module vcve2_vrf_seq
    import vcve2_pkg::*;
#(
    parameter int VLEN = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  vinstr_valid_i,
    output logic                  vinstr_ready_o,
    input  logic                  flush_i,
    input  logic [1:0]            num_reads_i,
    input  logic [VRF_ADDR_W-1:0] vs1_addr_i,
    input  logic [VRF_ADDR_W-1:0] vs2_addr_i,
    input  logic [VRF_ADDR_W-1:0] vd_addr_i,
    input  vop_a_sel_e            vop_a_sel_i,
    input  valu_op_e              valu_op_i,
    input  vsew_e                 vsew_i,
    input  logic [$clog2(VLEN):0] vl_i,
    input  logic [31:0]           rs1_data_i,
    input  logic [4:0]            imm_i,
    output logic                  vrf_req_o,
    output logic                  vrf_we_o,
    output logic [VRF_ADDR_W-1:0] vrf_addr_o,
    output logic [VLEN-1:0]       vrf_wdata_o,
    input  logic [VLEN-1:0]       vrf_rdata_i,
`ifdef VCVE2_VRF_SEQ_PERF_EN
    output logic [31:0]           vinstr_cnt_o,
`endif
    output logic                  vinstr_done_o,
    output logic                  vinstr_err_o
);

    localparam int VL_W = $clog2(VLEN) + 1;

    vrf_state_t            state_q, state_d;
    vinstr_t               instr_q;
    logic [VL_W-1:0]       vl_q;
    logic [31:0]           rs1_q;
    logic [4:0]            imm_q;
    rd_slot_e              slot_q, slot_d;
    logic [VLEN-1:0]       a_q, b_q, vd_old_q;
    logic [VLEN-1:0]       vs1_v, vs2_v, vd_old_v, op_a, result;
    logic [VRF_ADDR_W-1:0] addr_d;
    logic                  accept, err_d;
    vsew_e                 sew_nxt;

    assign accept  = vinstr_ready_o & vinstr_valid_i & ~flush_i;
    // On the accept edge the latched SEW is not there yet.
    assign sew_nxt = accept ? vsew_i : instr_q.sew;

    // ---------------- next-state decode ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            VRF_IDLE:  if (accept) state_d = (num_reads_i != 2'd0) ? VRF_READ1 : VRF_V_OP;
            VRF_READ1: state_d = flush_i ? VRF_IDLE :
                                 (instr_q.num_reads >= 2'd2) ? VRF_READ2 : VRF_V_OP;
            VRF_READ2: state_d = flush_i ? VRF_IDLE :
                                 (instr_q.num_reads == 2'd3) ? VRF_READ3 : VRF_V_OP;
            VRF_READ3: state_d = flush_i ? VRF_IDLE : VRF_V_OP;
            VRF_V_OP:  state_d = (flush_i || !vsew_valid(instr_q.sew)) ? VRF_IDLE : VRF_WRITE;
            VRF_WRITE: state_d = VRF_IDLE;
            default:   state_d = VRF_IDLE;
        endcase
    end

    // Address for the access issued in the next state. READ1 is only ever
    // entered from the accept edge, so vs2 comes straight from the input.
    always_comb begin
        addr_d = '0;
        case (state_d)
            VRF_READ1:            addr_d = vs2_addr_i;
            VRF_READ2:            addr_d = instr_q.vs1;
            VRF_READ3, VRF_WRITE: addr_d = instr_q.vd;
            default:              addr_d = '0;
        endcase
    end

    // Reserved SEW retires with an error in the V_OP cycle.
    assign err_d = (state_d == VRF_V_OP) && !vsew_valid(sew_nxt);

    // ---------------- FSM with registered outputs ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= VRF_IDLE;
            vinstr_ready_o <= 1'b1;
            vrf_req_o      <= 1'b0;
            vrf_we_o       <= 1'b0;
            vrf_addr_o     <= '0;
            vrf_wdata_o    <= '0;
            vinstr_done_o  <= 1'b0;
            vinstr_err_o   <= 1'b0;
        end else begin
            state_q        <= state_d;
            vinstr_ready_o <= (state_d == VRF_IDLE);
            vrf_req_o      <= (state_d == VRF_READ1) || (state_d == VRF_READ2) ||
                              (state_d == VRF_READ3) || (state_d == VRF_WRITE);
            vrf_we_o       <= (state_d == VRF_WRITE);
            vrf_addr_o     <= addr_d;
            // wdata doubles as the result register: loaded only on V_OP -> WRITE.
            vrf_wdata_o    <= (state_d == VRF_WRITE) ? result : '0;
            vinstr_done_o  <= (state_d == VRF_WRITE) || err_d;
            vinstr_err_o   <= err_d;
        end
    end

    // ---------------- read slot tracking / capture ----------------
    always_comb begin
        slot_d = SLOT_NONE;
        case (state_q)
            VRF_READ1: slot_d = SLOT_B;
            VRF_READ2: slot_d = SLOT_A;
            VRF_READ3: slot_d = SLOT_VD;
            default:   slot_d = SLOT_NONE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q  <= '0;
            vl_q     <= '0;
            rs1_q    <= '0;
            imm_q    <= '0;
            slot_q   <= SLOT_NONE;
            a_q      <= '0;
            b_q      <= '0;
            vd_old_q <= '0;
        end else begin
            slot_q <= slot_d;
            case (slot_q)
                SLOT_B:  b_q      <= vrf_rdata_i;
                SLOT_A:  a_q      <= vrf_rdata_i;
                SLOT_VD: vd_old_q <= vrf_rdata_i;
                default: ;
            endcase
            // Clearing on accept makes an unread slot read as zero; it is
            // placed after the capture so it wins over a stale capture.
            if (accept) begin
                instr_q.num_reads <= num_reads_i;
                instr_q.vs1       <= vs1_addr_i;
                instr_q.vd        <= vd_addr_i;
                instr_q.a_sel     <= vop_a_sel_i;
                instr_q.op        <= valu_op_i;
                instr_q.sew       <= vsew_i;
                vl_q              <= vl_i;
                rs1_q             <= rs1_data_i;
                imm_q             <= imm_i;
                a_q               <= '0;
                b_q               <= '0;
                vd_old_q          <= '0;
            end
        end
    end

    // The last read's data is still on vrf_rdata_i during V_OP: bypass it.
    assign vs2_v    = (slot_q == SLOT_B)  ? vrf_rdata_i : b_q;
    assign vs1_v    = (slot_q == SLOT_A)  ? vrf_rdata_i : a_q;
    assign vd_old_v = (slot_q == SLOT_VD) ? vrf_rdata_i : vd_old_q;

    always_comb begin
        op_a = '0;
        case (instr_q.a_sel)
            VOP_A_VREG_A: op_a = vs1_v;
            VOP_A_REG_A:  op_a = {(VLEN/32){sew_splat32(rs1_q, instr_q.sew)}};
            VOP_A_IMM:    op_a = {(VLEN/32){sew_splat32({{27{imm_q[4]}}, imm_q}, instr_q.sew)}};
            default:      op_a = '0;
        endcase
    end

    vcve2_valu #(.VLEN(VLEN)) u_valu (
        .op               (instr_q.op),
        .vsew             (instr_q.sew),
        .a                (op_a),
        .b                (vs2_v),
        .vl               (vl_q),
        .old_vd           (vd_old_v),
        .tail_undisturbed (instr_q.num_reads == 2'd3),
        .result           (result)
    );

`ifdef VCVE2_VRF_SEQ_PERF_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else if ((state_d == VRF_WRITE) && (cnt_q != 32'hFFFF_FFFF))
            cnt_q <= cnt_q + 32'd1;
    end

    assign vinstr_cnt_o = cnt_q;
`endif

endmodule
